mips_data_ram_ws: RTL and testbench
===================================

# mips_data_ram_ws

Parametrised data memory for the MIPS core test benches, replacing the fixed-latency, zero-wait combinational RAM models. It presents the same data-bus signals, adds byte-lane writes and a programmable wait-state handshake, and provides a self-initialising arithmetic-series preload sequenced after reset. It sits on the CPU data port in every test harness and lets the CPU's stall logic be exercised at any latency.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; power of two, 16..65536; AW = clog2(DEPTH_WORDS).
- WAIT_STATES, 0: wait cycles inserted per transfer, 0..15.
- INIT_WORDS, 15: words preloaded after reset, 0..DEPTH_WORDS.
- INIT_BASE, 32'h12345678: series first value.
- INIT_STEP, 32'hdcba1234: series difference.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- data_address  in  32  byte address.
- data_write  in  1  write request.
- data_read  in  1  read request.
- data_writedata  in  32  write data.
- data_byteenable  in  4  lane k enables bits [8k+7:8k].
- data_waitrequest  out  1  high = transfer not completed this cycle.
- data_readdata  out  32  read data, valid in the read completion cycle.
- data_fault  out  1  pulses in a completion cycle with an address or request error.

## Operation
- States: INIT, IDLE, BUSY. Reset forces INIT with init_idx=0 and ws_cnt=0.
- INIT: one word per cycle, mem[init_idx] <= byteswap(INIT_BASE + INIT_STEP*init_idx) mod 2^32. byteswap exchanges bytes 0↔3 and 1↔2. The state ends after INIT_WORDS cycles; INIT_WORDS=0 gives one INIT cycle. Requests are ignored; waitrequest=1.
- IDLE, no request: waitrequest=0, readdata=0, fault=0.
- Request = data_read | data_write. When ws_cnt < WAIT_STATES: waitrequest=1, ws_cnt increments, state BUSY. When ws_cnt == WAIT_STATES it is the completion cycle: waitrequest=0, the access happens, and ws_cnt returns to 0 at the edge.
- Back-to-back requests each pay the full WAIT_STATES.
- Word index = data_address[AW+1:2].
- Read completion: readdata = mem[index], combinational from the array in that cycle. At all other times readdata=0.
- Write completion: each lane with byteenable set is written at the closing edge. A read of the same word in a later cycle returns the new data.
- Faults, each pulsing data_fault in the completion cycle:
  - Out of range (data_address[31:AW+2] != 0): write dropped, readdata=0.
  - Misaligned (data_address[1:0] != 0): access uses the aligned-down word.
  - Read and write both high: treated as a write, readdata=0.
- Request dropped while in BUSY is a protocol violation. It is required to return to IDLE with ws_cnt=0 and no access.
- Address, data and byteenable are sampled only in the completion cycle.
- Reset asserted mid-transfer aborts the transfer with no write and restarts INIT. Words at or above INIT_WORDS keep their contents.

## Timing
- Reset values: waitrequest=1, readdata=0, fault=0; the same values hold throughout INIT.
- First acceptable request: cycle INIT_WORDS+1 after reset_n rises (cycle 2 when INIT_WORDS=0).
- Read latency: WAIT_STATES cycles of waitrequest=1, then data in the completion cycle (same cycle when WAIT_STATES=0).
- Write commit: the rising edge ending the completion cycle.
- waitrequest, readdata and fault are combinational from the request inputs, state and ws_cnt. There is no request-to-output register.

## Configuration
- DATA_RAM_BYTEENABLE_EN defined: byte-lane writes as above; byteenable=4'b0000 completes with no change.
- DATA_RAM_BYTEENABLE_EN undefined: data_byteenable is ignored and every write updates all 32 bits. The port remains present.

## Test plan
- Preload: defaults, release reset, read addresses 0x0, 0x4, 0x38 → 32'h78563412, byteswap(0xEEEE68AC)=32'hAC68EEEE, byteswap(0x12345678+14*0xdcba1234); waitrequest=1 for 15 cycles after reset_n rises.
- Wait states: WAIT_STATES=3, read 0x0 → waitrequest high 3 cycles, low in the 4th with data; a back-to-back second read again pays 3 cycles.
- Byte lanes: write 32'hAABBCCDD to 0x40 with byteenable 4'b0101 over prior 32'h0 → read 32'h00BB00DD. Without the macro → 32'hAABBCCDD.
- Faults: DEPTH_WORDS=4096, write to 0x4000 → fault pulse, memory unchanged. Read 0x6 → fault and the word at 0x4. Read+write together → fault, write performed.
- Reset mid-operation: WAIT_STATES=2, write 0x80 and assert reset_n low in the first wait cycle → word 0x80 unchanged after INIT, and the preload is rewritten.

Source files
------------

// File: rtl/mips_data_ram_ws.sv
// Wait-state data RAM for the MIPS data port: byte lanes, programmable latency, post-reset series preload.
// Optional byte-lane writes are enabled by defining DATA_RAM_BYTEENABLE_EN.
module mips_data_ram_ws #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned INIT_WORDS  = 15,
  parameter logic [31:0] INIT_BASE   = 32'h12345678,
  parameter logic [31:0] INIT_STEP   = 32'hdcba1234
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic        data_waitrequest,
  output logic [31:0] data_readdata,
  output logic        data_fault,
  output logic [1:0]  dbg_state
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);
  localparam logic [16:0] IW = 17'(INIT_WORDS);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  ws_cnt, ws_nx;
  logic [16:0] init_idx, init_idx_nx;
  logic [31:0] init_val, init_val_nx;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req, addr_oor, addr_mis, rw_both, complete;
  logic          init_we, acc_we;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;

  assign req      = data_read | data_write;
  assign addr_oor = |data_address[31:AW+2];
  assign addr_mis = |data_address[1:0];
  assign rw_both  = data_read & data_write;
  assign word_idx = data_address[AW+1:2];

`ifdef DATA_RAM_BYTEENABLE_EN
  assign lane_en = data_byteenable;
`else
  logic unused_be;
  assign unused_be = ^data_byteenable;
  assign lane_en   = 4'hF;
`endif

  function automatic logic [31:0] byteswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Handshake: a request (read|write) is held until a cycle with waitrequest=0;
  // that cycle is the completion cycle, and only then are address/data/byteenable used.
  always_comb begin
    state_nx         = state;
    ws_nx            = ws_cnt;
    init_idx_nx      = init_idx;
    init_val_nx      = init_val;
    data_waitrequest = 1'b0;
    data_readdata    = 32'h0;
    data_fault       = 1'b0;
    complete         = 1'b0;
    init_we          = 1'b0;
    case (state)
      ST_INIT: begin
        data_waitrequest = 1'b1;
        init_we          = (IW != 17'd0);
        init_idx_nx      = init_idx + 17'd1;
        init_val_nx      = init_val + INIT_STEP;
        if (IW == 17'd0 || init_idx == IW - 17'd1) state_nx = ST_IDLE;
      end
      default: begin
        if (!req) begin
          // covers the protocol violation of dropping a request in BUSY
          state_nx = ST_IDLE;
          ws_nx    = 4'd0;
        end else if (ws_cnt != WS) begin
          data_waitrequest = 1'b1;
          ws_nx            = ws_cnt + 4'd1;
          state_nx         = ST_BUSY;
        end else begin
          complete   = 1'b1;
          ws_nx      = 4'd0;
          state_nx   = ST_IDLE;
          data_fault = addr_oor | addr_mis | rw_both;
          if (data_read && !data_write && !addr_oor) data_readdata = mem[word_idx];
        end
      end
    endcase
  end

  assign acc_we    = complete & data_write & ~addr_oor;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      ws_cnt   <= 4'd0;
      init_idx <= 17'd0;
      init_val <= INIT_BASE;
    end else begin
      state    <= state_nx;
      ws_cnt   <= ws_nx;
      init_idx <= init_idx_nx;
      init_val <= init_val_nx;
    end
  end

  // Storage has no reset so words beyond the preload survive a reset.
  always_ff @(posedge clk) begin
    if (reset_n && init_we) begin
      mem[init_idx[AW-1:0]] <= byteswap(init_val);
    end else if (reset_n && acc_we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[word_idx][8*k +: 8] <= data_writedata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_data_ram_ws.sv
// Self-checking bench for mips_data_ram_ws: directed vector table, multi-cycle corner sequences, randomized traffic.
module tb_mips_data_ram_ws;

  localparam int          DEPTH = 4096;
  localparam int          WS    = 3;
  localparam int          IW    = 15;
  localparam logic [31:0] BASE  = 32'h12345678;
  localparam logic [31:0] STEP  = 32'hdcba1234;
`ifdef DATA_RAM_BYTEENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic        data_waitrequest;
  logic [31:0] data_readdata;
  logic        data_fault;
  logic [1:0]  dbg_state;

  mips_data_ram_ws #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .INIT_WORDS (IW),
    .INIT_BASE  (BASE),
    .INIT_STEP  (STEP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .data_address    (data_address),
    .data_write      (data_write),
    .data_read       (data_read),
    .data_writedata  (data_writedata),
    .data_byteenable (data_byteenable),
    .data_waitrequest(data_waitrequest),
    .data_readdata   (data_readdata),
    .data_fault      (data_fault),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] model_mem [DEPTH];
  logic [32:0] exp_q[$];

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_flt;
  } vec_t;

  vec_t vt[14];

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference model: word array with arithmetic preload
  task automatic model_preload();
    for (int i = 0; i < IW; i++) model_mem[i] = bswap(BASE + STEP * 32'(i));
  endtask

  task automatic model_access(input logic [31:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [3:0] be,
                              output logic [31:0] erd, output logic eflt);
    int unsigned widx;
    bit oor;
    widx = addr >> 2;
    oor  = (widx >= DEPTH);
    eflt = oor || (addr % 4 != 0) || (rd && wr);
    erd  = (rd && !wr && !oor) ? model_mem[widx] : 32'h0;
    if (wr && !oor)
      for (int k = 0; k < 4; k++)
        if (!BE_EN || be[k]) model_mem[widx][8*k +: 8] = wd[8*k +: 8];
  endtask

  // driver: starts at posedge+1, returns at posedge+1 after the completion edge
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rdata, output logic flt, output int waits);
    data_address    = addr;
    data_read       = rd;
    data_write      = wr;
    data_writedata  = wd;
    data_byteenable = be;
    waits = 0;
    rdata = 32'h0;
    flt   = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!data_waitrequest) begin
        rdata = data_readdata;
        flt   = data_fault;
        break;
      end
      waits++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check();
    data_read  = 1'b0;
    data_write = 1'b0;
    @(negedge clk);
    check("idle wait", 32'(data_waitrequest), 32'd0);
    check("idle rdata", data_readdata, 32'h0);
    check("idle fault", 32'(data_fault), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // model-checked transfer through the scoreboard queue
  task automatic sb_xfer(input string name, input logic [31:0] addr, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] erd, ard;
    logic        eflt, aflt;
    logic [32:0] e;
    int          waits;
    model_access(addr, rd, wr, wd, be, erd, eflt);
    exp_q.push_back({eflt, erd});
    xfer(addr, rd, wr, wd, be, ard, aflt, waits);
    e = exp_q.pop_front();
    check({name, " rdata"}, ard, e[31:0]);
    check({name, " fault"}, 32'(aflt), 32'(e[32]));
    check({name, " waits"}, 32'(waits), 32'(WS));
  endtask

  initial begin
    logic [31:0] ard, addr, wd;
    logic        aflt, rd, wr;
    int          waits, init_hi, init_bad, mode;

    vt[0]  = '{"rd 0x0",     32'h0,     1, 0, 32'h0,        4'hF, 32'h78563412, 0};
    vt[1]  = '{"rd 0x4",     32'h4,     1, 0, 32'h0,        4'hF, 32'hAC68EEEE, 0};
    vt[2]  = '{"rd 0x38",    32'h38,    1, 0, 32'h0,        4'hF, bswap(BASE + STEP * 32'd14), 0};
    vt[3]  = '{"clr 0x40",   32'h40,    0, 1, 32'h0,        4'hF, 32'h0, 0};
    vt[4]  = '{"be 0x40",    32'h40,    0, 1, 32'hAABBCCDD, 4'h5, 32'h0, 0};
    vt[5]  = '{"rd 0x40",    32'h40,    1, 0, 32'h0,        4'hF, BE_EN ? 32'h00BB00DD : 32'hAABBCCDD, 0};
    vt[6]  = '{"oor wr",     32'h4000,  0, 1, 32'hDEADBEEF, 4'hF, 32'h0, 1};
    vt[7]  = '{"rd 0x0 kept",32'h0,     1, 0, 32'h0,        4'hF, 32'h78563412, 0};
    vt[8]  = '{"mis rd 0x6", 32'h6,     1, 0, 32'h0,        4'hF, 32'hAC68EEEE, 1};
    vt[9]  = '{"rw both",    32'h44,    1, 1, 32'hCAFEF00D, 4'hF, 32'h0, 1};
    vt[10] = '{"rd 0x44",    32'h44,    1, 0, 32'h0,        4'hF, 32'hCAFEF00D, 0};
    vt[11] = '{"oor rd",     32'h10000, 1, 0, 32'h0,        4'hF, 32'h0, 1};
    vt[12] = '{"be0 wr",     32'h40,    0, 1, 32'h11223344, 4'h0, 32'h0, 0};
    vt[13] = '{"rd be0",     32'h40,    1, 0, 32'h0,        4'hF, BE_EN ? 32'h00BB00DD : 32'h11223344, 0};

    reset_n = 1'b0;
    data_address = 32'h0; data_read = 1'b0; data_write = 1'b0;
    data_writedata = 32'h0; data_byteenable = 4'hF;
    model_preload();

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset wait", 32'(data_waitrequest), 32'd1);
    check("reset rdata", data_readdata, 32'h0);
    check("reset fault", 32'(data_fault), 32'd0);

    // preload window: a read held throughout INIT must be ignored
    data_read = 1'b1;
    reset_n   = 1'b1;
    init_hi = 0; init_bad = 0;
    for (int c = 0; c < IW; c++) begin
      @(negedge clk);
      if (data_waitrequest) init_hi++;
      if (data_readdata != 32'h0 || data_fault) init_bad++;
    end
    check("init wait cycles", 32'(init_hi), 32'(IW));
    check("init quiet outputs", 32'(init_bad), 32'd0);
    @(posedge clk);
    #1;
    idle_check();

    // directed table, back-to-back
    for (int i = 0; i < 14; i++) begin
      logic [31:0] erd;
      logic        eflt;
      model_access(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].wd, vt[i].be, erd, eflt);
      xfer(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].wd, vt[i].be, ard, aflt, waits);
      check({vt[i].name, " rdata"}, ard, vt[i].exp_rd);
      check({vt[i].name, " fault"}, 32'(aflt), 32'(vt[i].exp_flt));
      check({vt[i].name, " waits"}, 32'(waits), 32'(WS));
    end
    idle_check();

    // fill words 15..63 so every word touched later is known
    for (int w = 15; w < 64; w++) sb_xfer("fill", 32'(w) << 2, 1'b0, 1'b1, $urandom, 4'hF);

    // request dropped in BUSY: back to IDLE, no access, counter cleared
    data_address = 32'h48; data_write = 1'b1; data_read = 1'b0;
    data_writedata = 32'h5A5A5A5A; data_byteenable = 4'hF;
    @(negedge clk);
    check("drop first wait", 32'(data_waitrequest), 32'd1);
    @(posedge clk);
    #1;
    data_write = 1'b0;
    @(negedge clk);
    check("drop wait", 32'(data_waitrequest), 32'd0);
    check("drop fault", 32'(data_fault), 32'd0);
    @(posedge clk);
    #1;
    sb_xfer("after drop", 32'h48, 1'b1, 1'b0, 32'h0, 4'hF);

    // reset in the first wait cycle of a write
    sb_xfer("pre-reset wr", 32'h0, 1'b0, 1'b1, 32'h55AA55AA, 4'hF);
    data_address = 32'h80; data_write = 1'b1; data_read = 1'b0;
    data_writedata = 32'h0BADF00D; data_byteenable = 4'hF;
    @(negedge clk);
    check("abort first wait", 32'(data_waitrequest), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort reset wait", 32'(data_waitrequest), 32'd1);
    check("abort reset rdata", data_readdata, 32'h0);
    data_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (IW + 1) @(posedge clk);
    #1;
    model_preload();
    sb_xfer("abort 0x80", 32'h80, 1'b1, 1'b0, 32'h0, 4'hF);
    sb_xfer("repreload 0x0", 32'h0, 1'b1, 1'b0, 32'h0, 4'hF);
    sb_xfer("repreload 0x38", 32'h38, 1'b1, 1'b0, 32'h0, 4'hF);
    sb_xfer("kept 0x3C", 32'h3C, 1'b1, 1'b0, 32'h0, 4'hF);

    // randomized traffic against the model
    for (int n = 0; n < 250; n++) begin
      addr = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
      mode = $urandom_range(0, 9);
      rd = (mode <= 4);
      wr = (mode == 0) || (mode >= 5);
      wd = $urandom;
      sb_xfer("rand", addr, rd, wr, wd, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle_check();
    end
    idle_check();

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
